// File: rtl/eth_rmii_rx.sv
// ---------------------------------------------------------------------------
// eth_rmii_rx
//
// RMII receive front end for the 100 Mb/s Ethernet capture path. It samples
// RXD[1:0] and CRS_DV on the 50 MHz reference clock and strips the preamble
// and SFD. It then packs the LSB-first dibits into bytes and presents a byte
// stream with start- and end-of-packet markers.
//
// Parameters
//   MAXLEN       maximum accepted bytes per frame, FCS included (64..4095)
//
// Ports
//   clk          50 MHz RMII reference clock, the only clock
//   reset        asynchronous, active-high reset
//   rmii_rxd     RMII RXD[1:0], LSB dibit first
//   rmii_crs_dv  RMII CRS_DV
//   rxdata       received byte, valid while rxvalid is high
//   rxvalid      one-cycle strobe per received byte
//   rxsop        high together with the first data byte of a frame
//   rxeop        one-cycle pulse after the last byte (rxvalid low that cycle)
//   rxerr        frame-bad flag, qualified by rxeop
//
// Configuration macro
//   ETH_RMII_RX_CRC_EN  when defined, adds a CRC-32 check over every accepted
//                       byte, FCS included. A bad residue is then reported on
//                       rxerr. When undefined, no CRC logic is built.
// ---------------------------------------------------------------------------
module eth_rmii_rx #(
   parameter int MAXLEN = 1536
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] rmii_rxd,
   input  logic       rmii_crs_dv,
   output logic [7:0] rxdata,
   output logic       rxvalid,
   output logic       rxsop,
   output logic       rxeop,
   output logic       rxerr
);

   typedef enum logic [2:0] {SYNC, IDLE, PRE, DATA, EOP} state_t;

   localparam logic [11:0] MAX_BYTES = 12'(MAXLEN);

   logic [1:0]  r_rxd1, r_rxd2;
   logic        r_crs1, r_crs2;
   state_t      r_state, w_next;
   logic [7:0]  r_shreg;
   logic [1:0]  r_dcnt;
   logic [11:0] r_bcnt;
   logic        r_sopPend;
   logic        r_ovl;
   logic [7:0]  r_rxdata;
   logic        r_rxvalid, r_rxsop, r_rxeop, r_rxerr;

   logic        w_isData, w_carrierOff, w_enterData, w_underMax, w_accept;
   logic [7:0]  w_byte;
   logic        w_crcBad;

   // Two-stage input pipeline. The CRS_DV stages come out of reset high.
   // This makes SYNC wait for a genuinely idle line after reset, so a frame
   // that is still running when reset is released is ignored instead of
   // being locked onto halfway through.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rxd1 <= 2'b00;
         r_rxd2 <= 2'b00;
         r_crs1 <= 1'b1;
         r_crs2 <= 1'b1;
      end else begin
         r_rxd1 <= rmii_rxd;
         r_crs1 <= rmii_crs_dv;
         r_rxd2 <= r_rxd1;
         r_crs2 <= r_crs1;
      end
   end

   // At carrier loss the PHY toggles CRS_DV at nibble rate, so a dibit
   // counts as data while either pipeline stage still shows carrier. The
   // frame ends only once both stages show the carrier has gone.
   assign w_isData     = r_crs2 | r_crs1;
   assign w_carrierOff = ~r_crs2 & ~r_crs1;
   assign w_byte       = {r_rxd2, r_shreg[7:2]};
   assign w_underMax   = (r_bcnt < MAX_BYTES);
   assign w_accept     = (r_state == DATA) && w_isData && (r_dcnt == 2'd3) && w_underMax;
   assign w_enterData  = (r_state == PRE) && (w_next == DATA);

   // State register for the framing FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic. SYNC waits out any frame in progress. IDLE looks for
   // the first preamble dibit. PRE follows the preamble up to the SFD tail.
   // DATA runs until carrier loss. EOP lasts one cycle to issue the marker.
   always_comb begin
      w_next = r_state;
      case (r_state)
         SYNC: begin
            if (w_carrierOff) w_next = IDLE;
         end
         IDLE: begin
            if (r_crs2) begin
               if (r_rxd2 == 2'b01)      w_next = PRE;
               else if (r_rxd2 != 2'b00) w_next = SYNC;
            end
         end
         PRE: begin
            if (!r_crs2)                 w_next = SYNC;
            else if (r_rxd2 == 2'b11)    w_next = DATA;
            else if (r_rxd2 != 2'b01)    w_next = SYNC;
         end
         DATA: begin
            if (w_carrierOff) w_next = EOP;
         end
         EOP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = SYNC;
         end
      endcase
   end

`ifdef ETH_RMII_RX_CRC_EN
   logic [31:0] r_crc;

   // Reflected CRC-32 (0xEDB88320) advanced by one byte, LSB first.
   function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      end
      return x;
   endfunction

   // The CRC runs over every accepted byte, FCS included. A good frame
   // therefore leaves the fixed residue in the register. The register is
   // preset when the SFD is recognised.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_crc <= 32'hFFFFFFFF;
      end else if (w_enterData) begin
         r_crc <= 32'hFFFFFFFF;
      end else if (w_accept) begin
         r_crc <= crcByte(r_crc, w_byte);
      end
   end

   assign w_crcBad = (r_crc != 32'hDEBB20E3);
`else
   assign w_crcBad = 1'b0;
`endif

   // Byte assembly and output registers. Dibits shift in from the top so
   // the first dibit ends up in bits [1:0]. The byte counter keeps counting
   // (saturating) past MAXLEN, so bytes beyond the limit are dropped and
   // flag the frame as overlength. The error summary also covers a frame
   // that ended on a partial byte or delivered no whole bytes at all.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shreg   <= 8'd0;
         r_dcnt    <= 2'd0;
         r_bcnt    <= 12'd0;
         r_sopPend <= 1'b0;
         r_ovl     <= 1'b0;
         r_rxdata  <= 8'd0;
         r_rxvalid <= 1'b0;
         r_rxsop   <= 1'b0;
         r_rxeop   <= 1'b0;
         r_rxerr   <= 1'b0;
      end else begin
         r_rxvalid <= 1'b0;
         r_rxsop   <= 1'b0;
         r_rxeop   <= 1'b0;
         r_rxerr   <= 1'b0;
         if (w_enterData) begin
            r_dcnt    <= 2'd0;
            r_bcnt    <= 12'd0;
            r_sopPend <= 1'b1;
            r_ovl     <= 1'b0;
         end else if (r_state == DATA && w_isData) begin
            r_shreg <= w_byte;
            r_dcnt  <= r_dcnt + 2'd1;
            if (r_dcnt == 2'd3) begin
               if (r_bcnt != 12'hFFF) r_bcnt <= r_bcnt + 12'd1;
               if (w_underMax) begin
                  r_rxdata  <= w_byte;
                  r_rxvalid <= 1'b1;
                  r_rxsop   <= r_sopPend;
                  r_sopPend <= 1'b0;
               end else begin
                  r_ovl <= 1'b1;
               end
            end
         end
         if (r_state == EOP) begin
            r_rxeop <= 1'b1;
            r_rxerr <= (r_dcnt != 2'd0) | r_ovl | w_crcBad | (r_bcnt == 12'd0);
         end
      end
   end

   assign rxdata  = r_rxdata;
   assign rxvalid = r_rxvalid;
   assign rxsop   = r_rxsop;
   assign rxeop   = r_rxeop;
   assign rxerr   = r_rxerr;

endmodule

// File: tb/tb_eth_rmii_rx.sv
// ---------------------------------------------------------------------------
// tb_eth_rmii_rx
//
// Self-checking bench for eth_rmii_rx, built with MAXLEN=64.
//
// Frames are described as byte lists. A reference model turns each byte list
// into the expected byte stream and end-of-frame error flag and pushes them
// into a queue. A monitor process then pops and compares whenever the DUT
// strobes rxvalid or rxeop. The CRC expectation is derived by checking the
// trailing FCS against a CRC-32 of the preceding bytes.
// ---------------------------------------------------------------------------
module tb_eth_rmii_rx;

   localparam int MAXLEN = 64;
`ifdef ETH_RMII_RX_CRC_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] rmii_rxd;
   logic       rmii_crs_dv;
   logic [7:0] rxdata;
   logic       rxvalid, rxsop, rxeop, rxerr;

   typedef struct {
      bit         isEop;
      logic [7:0] data;
      bit         sop;
      bit         err;
   } exp_t;

   exp_t       expQ[$];
   exp_t       monItem;
   logic [7:0] txBytes[$];
   int         checks = 0;
   int         errors = 0;

   eth_rmii_rx #(.MAXLEN(MAXLEN)) dut (
      .clk         (clk),
      .reset       (reset),
      .rmii_rxd    (rmii_rxd),
      .rmii_crs_dv (rmii_crs_dv),
      .rxdata      (rxdata),
      .rxvalid     (rxvalid),
      .rxsop       (rxsop),
      .rxeop       (rxeop),
      .rxerr       (rxerr)
   );

   // 50 MHz reference clock.
   always #10 clk = ~clk;

   // Hard stop in case the bench somehow stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Standard Ethernet CRC-32 (final value, complemented) over txBytes[0..n-1].
   function automatic logic [31:0] crcOf(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'd0, txBytes[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // True when the last four of the first n bytes form a valid FCS for the rest.
   function automatic bit fcsOk(input int n);
      if (n < 4) return 1'b0;
      return crcOf(n - 4) == {txBytes[n-1], txBytes[n-2], txBytes[n-3], txBytes[n-4]};
   endfunction

   // Build a frame with payloadLen bytes (sequential or random) plus a correct FCS.
   task automatic buildFrame(input int payloadLen, input bit sequential);
      logic [31:0] fcs;
      txBytes.delete();
      for (int i = 0; i < payloadLen; i++) txBytes.push_back(sequential ? 8'(i) : 8'($urandom));
      fcs = crcOf(payloadLen);
      for (int k = 0; k < 4; k++) txBytes.push_back(fcs[8*k +: 8]);
   endtask

   // Reference model: bytes delivered are the first min(n, MAXLEN). A frame cut
   // by reset delivers only the bytes before the reset and no end marker.
   // Otherwise the frame is bad if it ended on a partial byte, was too long,
   // was empty, or (with the CRC built in) failed the FCS check.
   task automatic modelFrame(input int extraDibits, input int resetAtByte);
      int   n, acc;
      exp_t e;
      bit   bad;
      n   = txBytes.size();
      acc = (n > MAXLEN) ? MAXLEN : n;
      if (resetAtByte >= 0 && resetAtByte < acc) acc = resetAtByte;
      for (int i = 0; i < acc; i++) begin
         e.isEop = 1'b0; e.data = txBytes[i]; e.sop = (i == 0); e.err = 1'b0;
         expQ.push_back(e);
      end
      if (resetAtByte < 0) begin
         bad = ((extraDibits % 4) != 0) || (n > MAXLEN) || (n == 0);
         if (CRC_EN && !fcsOk(acc)) bad = 1'b1;
         e.isEop = 1'b1; e.data = 8'd0; e.sop = 1'b0; e.err = bad;
         expQ.push_back(e);
      end
   endtask

   task automatic drive(input logic [1:0] d, input logic c);
      @(negedge clk);
      rmii_rxd    = d;
      rmii_crs_dv = c;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive(2'b00, 1'b0);
   endtask

   // Send preamble, SFD and txBytes, optionally with trailing dibits, CRS_DV
   // toggling over the last two bytes, or a reset pulse inside byte resetAtByte.
   task automatic applyStimulus(input int extraDibits, input bit toggleTail, input int resetAtByte);
      int         nd;
      logic [7:0] b;
      logic [1:0] d;
      logic       c;
      for (int i = 0; i < 32; i++) drive((i == 31) ? 2'b11 : 2'b01, 1'b1);
      nd = txBytes.size() * 4;
      for (int j = 0; j < nd + extraDibits; j++) begin
         if (j < nd) begin
            b = txBytes[j / 4];
            d = b[2*(j % 4) +: 2];
         end else begin
            d = 2'($urandom);
         end
         c = !(toggleTail && j >= nd - 8 && j < nd && (j % 2) == 0);
         @(negedge clk);
         if (resetAtByte >= 0 && j == 4 * resetAtByte + 3) begin
            #2 reset = 1'b1;
            #1;
            checkOutput("midreset rxdata",  32'(rxdata),  32'd0);
            checkOutput("midreset rxvalid", 32'(rxvalid), 32'd0);
            checkOutput("midreset rxsop",   32'(rxsop),   32'd0);
            checkOutput("midreset rxeop",   32'(rxeop),   32'd0);
            checkOutput("midreset rxerr",   32'(rxerr),   32'd0);
         end
         if (resetAtByte >= 0 && j == 4 * resetAtByte + 6) reset = 1'b0;
         rmii_rxd    = d;
         rmii_crs_dv = c;
      end
      idle(48);
   endtask

   // Wait (bounded) for every expected item to be consumed by the monitor.
   task automatic drain(input string name);
      int waited;
      waited = 0;
      while (expQ.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(name, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   task automatic runFrame(input string name, input int extra, input bit toggle, input int rstAt);
      modelFrame(extra, rstAt);
      applyStimulus(extra, toggle, rstAt);
      drain(name);
   endtask

   // Monitor: pops the scoreboard on every byte strobe and end marker, and
   // checks that rxsop never appears without rxvalid and rxeop never with it.
   always @(negedge clk) begin
      if (!reset) begin
         if (rxsop) checkOutput("sop without valid", 32'(rxvalid), 32'd1);
         if (rxeop) checkOutput("eop with valid", 32'(rxvalid), 32'd0);
         if (rxvalid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected byte", 32'(rxdata), 32'h100);
            end else begin
               monItem = expQ.pop_front();
               checkOutput("byte slot", 32'(monItem.isEop), 32'd0);
               checkOutput("rxdata", 32'(rxdata), 32'(monItem.data));
               checkOutput("rxsop", 32'(rxsop), 32'(monItem.sop));
            end
         end
         if (rxeop) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected eop", 32'(rxerr), 32'h100);
            end else begin
               monItem = expQ.pop_front();
               checkOutput("eop slot", 32'(monItem.isEop), 32'd1);
               checkOutput("rxerr", 32'(rxerr), 32'(monItem.err));
            end
         end
      end
   end

   initial begin
      int len;
      reset       = 1'b1;
      rmii_rxd    = 2'b00;
      rmii_crs_dv = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset rxdata",  32'(rxdata),  32'd0);
      checkOutput("reset rxvalid", 32'(rxvalid), 32'd0);
      checkOutput("reset rxsop",   32'(rxsop),   32'd0);
      checkOutput("reset rxeop",   32'(rxeop),   32'd0);
      checkOutput("reset rxerr",   32'(rxerr),   32'd0);
      reset = 1'b0;
      idle(10);

      $display("[TB] good frame");
      buildFrame(60, 1'b1);
      runFrame("good frame", 0, 1'b0, -1);

      $display("[TB] CRS_DV toggling at end of frame");
      runFrame("toggle frame", 0, 1'b1, -1);

      $display("[TB] bad FCS");
      txBytes[60] = txBytes[60] ^ 8'h01;
      runFrame("bad fcs frame", 0, 1'b0, -1);

      $display("[TB] trailing partial byte");
      buildFrame(60, 1'b1);
      runFrame("partial frame", 1, 1'b0, -1);

      $display("[TB] reset mid-frame, then a good frame");
      runFrame("reset frame", 0, 1'b0, 20);
      runFrame("after reset frame", 0, 1'b0, -1);

      $display("[TB] overlength frame");
      buildFrame(96, 1'b0);
      runFrame("overlength frame", 0, 1'b0, -1);

      $display("[TB] frame with no whole bytes");
      txBytes.delete();
      runFrame("empty frame", 0, 1'b0, -1);

      $display("[TB] false carrier and aborted preamble");
      for (int i = 0; i < 10; i++) drive(2'b10, 1'b1);
      idle(48);
      for (int i = 0; i < 10; i++) drive(2'b01, 1'b1);
      for (int i = 0; i < 5; i++) drive(2'b00, 1'b1);
      idle(48);
      drain("false carrier");
      buildFrame(20, 1'b0);
      runFrame("after false carrier", 0, 1'b0, -1);

      $display("[TB] random frames");
      for (int f = 0; f < 25; f++) begin
         len = int'($urandom_range(0, 70));
         buildFrame(len, 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            len = int'($urandom_range(0, txBytes.size() - 1));
            txBytes[len] = txBytes[len] ^ (8'd1 << $urandom_range(0, 7));
         end
         runFrame("random frame", ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                  1'($urandom_range(0, 1)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
